// File: rtl/uart8_led_sequencer_pkg.sv
// uart8_led_sequencer_pkg: shared register map, CTRL bit positions and FSM encoding
package uart8_led_sequencer_pkg;
   localparam logic [1:0] ADDR_CTRL    = 2'd0;
   localparam logic [1:0] ADDR_PERIOD  = 2'd1;
   localparam logic [1:0] ADDR_PATTERN = 2'd2;
   localparam logic [1:0] ADDR_STATUS  = 2'd3;
   localparam int CTRL_EN   = 0;
   localparam int CTRL_LOOP = 1;
   localparam int NSTEPS    = 4;
   localparam int STEP_W    = $clog2(NSTEPS);
   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WR_STEP = 2'd1,
      S_WAIT    = 2'd2,
      S_WR_CLR  = 2'd3
   } state_t;
endpackage

// File: rtl/uart8_led_step_timer.sv
// uart8_led_step_timer: loadable down-counter whose done pulse marks the last cycle of a step
module uart8_led_step_timer #(
   parameter int W = 24
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_run,
   output logic         o_done
);
   logic [W-1:0] r_cnt;
   // reload when a step write is accepted, count down while the step is displayed
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_cnt <= '0;
      else if (i_load) r_cnt <= i_load_val;
      else if (i_run && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
   end
   assign o_done = i_run && (r_cnt == W'(1));
endmodule

// File: rtl/uart8_led_sequencer.sv
// uart8_led_sequencer: Avalon-MM controller stepping the LED PIO through up to four patterns
module uart8_led_sequencer
   import uart8_led_sequencer_pkg::*;
#(
   parameter int PERIOD_W = 24,
   parameter int LED_W    = 3
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic [1:0]  m_address,
   output logic        m_write,
   output logic [31:0] m_writedata,
   input  logic        m_waitrequest,
   output logic        busy
);
   logic [PERIOD_W-1:0]     r_period;
   logic [NSTEPS*LED_W-1:0] r_pattern;
   logic                    r_en;
   logic                    r_loop;
   logic [STEP_W-1:0]       r_step;
   logic [LED_W-1:0]        r_wdata;
   state_t                  r_state;
   state_t                  w_state_nx;
   logic [STEP_W-1:0]       w_step_nx;
   logic                    w_wr;
   logic                    w_ctrl_wr;
   logic                    w_abort;
   logic                    w_accept;
   logic                    w_done;
   logic [PERIOD_W-1:0]     w_load_val;
   logic                    w_unused;

   assign w_wr       = chipselect && !write_n;
   assign w_ctrl_wr  = w_wr && (address == ADDR_CTRL);
   // a pending abort is either an EN=0 write this cycle or one that landed during a stalled step write
   assign w_abort    = !r_en || (w_ctrl_wr && !writedata[CTRL_EN]);
   assign w_accept   = m_write && !m_waitrequest;
   assign w_load_val = (r_period == '0) ? PERIOD_W'(1) : r_period;
   assign w_unused   = ^writedata;

   uart8_led_step_timer #(.W(PERIOD_W)) u_timer (
      .clk        (clk),
      .reset_n    (reset_n),
      .i_load     (r_state == S_WR_STEP && w_accept),
      .i_load_val (w_load_val),
      .i_run      (r_state == S_WAIT),
      .o_done     (w_done)
   );

   // register file: EN only changes on start, abort, or completion of the clear write
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_period  <= '0;
         r_pattern <= '0;
         r_en      <= 1'b0;
         r_loop    <= 1'b0;
      end else begin
         if (w_wr && address == ADDR_PERIOD) r_period <= writedata[PERIOD_W-1:0];
         if (w_wr && address == ADDR_PATTERN) r_pattern <= writedata[NSTEPS*LED_W-1:0];
         if (w_ctrl_wr) begin
            r_loop <= writedata[CTRL_LOOP];
            if (r_state == S_IDLE || !writedata[CTRL_EN]) r_en <= writedata[CTRL_EN];
         end
         if (r_state == S_WR_CLR && w_accept) r_en <= 1'b0;
      end
   end

   // next-state and step index; master requests are held until accepted
   always_comb begin
      w_state_nx = r_state;
      w_step_nx  = r_step;
      case (r_state)
         S_IDLE: if (w_ctrl_wr && writedata[CTRL_EN]) begin
            w_state_nx = S_WR_STEP;
            w_step_nx  = '0;
         end
         S_WR_STEP: if (!m_waitrequest) w_state_nx = w_abort ? S_WR_CLR : S_WAIT;
         S_WAIT: if (w_abort) w_state_nx = S_WR_CLR;
            else if (w_done) begin
               if (r_step != STEP_W'(NSTEPS - 1) || r_loop) begin
                  w_state_nx = S_WR_STEP;
                  w_step_nx  = r_step + 1'b1;
               end else w_state_nx = S_WR_CLR;
            end
         S_WR_CLR: if (!m_waitrequest) w_state_nx = S_IDLE;
         default: w_state_nx = S_IDLE;
      endcase
   end

   // state register; the step pattern is captured on entry so later PATTERN writes cannot disturb a held write
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_step  <= '0;
         r_wdata <= '0;
      end else begin
         r_state <= w_state_nx;
         r_step  <= w_step_nx;
         if (w_state_nx == S_WR_STEP && r_state != S_WR_STEP) r_wdata <= r_pattern[w_step_nx*LED_W +: LED_W];
      end
   end

   assign m_address   = 2'd0;
   assign m_write     = (r_state == S_WR_STEP) || (r_state == S_WR_CLR);
   assign m_writedata = (r_state == S_WR_STEP) ? {{(32-LED_W){1'b0}}, r_wdata} : 32'd0;
   assign busy        = (r_state != S_IDLE);
   assign readdata    = !chipselect                ? 32'd0 :
                        (address == ADDR_CTRL)     ? 32'({r_loop, r_en}) :
                        (address == ADDR_PERIOD)   ? 32'(r_period) :
                        (address == ADDR_PATTERN)  ? 32'(r_pattern) :
                                                     32'({r_step, 3'b000, busy});
endmodule

// File: tb/tb_uart8_led_sequencer.sv
// tb_uart8_led_sequencer: random and directed stimulus checked every cycle against a timeline model
module tb_uart8_led_sequencer;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [1:0]  address = '0;
   logic        chipselect = 1'b0;
   logic        write_n = 1'b1;
   logic [31:0] writedata = '0;
   logic        m_waitrequest = 1'b0;
   logic [31:0] readdata;
   logic [1:0]  m_address;
   logic        m_write;
   logic [31:0] m_writedata;
   logic        busy;

   uart8_led_sequencer dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .address       (address),
      .chipselect    (chipselect),
      .write_n       (write_n),
      .writedata     (writedata),
      .readdata      (readdata),
      .m_address     (m_address),
      .m_write       (m_write),
      .m_writedata   (m_writedata),
      .m_waitrequest (m_waitrequest),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   longint cyc = 0;

   // model: 0 idle, 1 step write pending, 2 showing a step until md_wait_end, 3 clear write pending
   bit     md_en, md_loop;
   int     md_period, md_pattern, md_phase, md_step, md_data;
   longint md_wait_end;
   int     acc_data[$];
   longint acc_cyc[$];

   function automatic int pat(int p, int k);
      return (p >> (3 * k)) & 7;
   endfunction

   function automatic int pmax(int p);
      return (p == 0) ? 1 : p;
   endfunction

   function automatic logic [31:0] exp_rd(int a);
      case (a)
         0: return {30'b0, md_loop, md_en};
         1: return md_period;
         2: return md_pattern;
         default: return (md_step << 4) | ((md_phase != 0) ? 1 : 0);
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic model_reset();
      md_en = 0; md_loop = 0; md_period = 0; md_pattern = 0;
      md_phase = 0; md_step = 0; md_data = 0; md_wait_end = 0;
   endtask

   task automatic cyc_step(input bit wr, input int wa, input int wd, input bit rd, input int ra, input bit wreq);
      bit ctrl_wr, abort;
      int ph;
      @(negedge clk);
      chipselect = wr || rd;
      write_n = !wr;
      address = 2'(wr ? wa : ra);
      writedata = wd;
      m_waitrequest = wreq;
      #1;
      chk("m_write", {31'b0, m_write}, (md_phase == 1 || md_phase == 3) ? 1 : 0);
      chk("m_writedata", m_writedata, (md_phase == 1) ? md_data : 0);
      chk("m_address", {30'b0, m_address}, 0);
      chk("busy", {31'b0, busy}, (md_phase != 0) ? 1 : 0);
      if (rd && !wr) chk("readdata", readdata, exp_rd(ra));
      if ((md_phase == 1 || md_phase == 3) && !wreq) begin
         acc_data.push_back(md_phase == 1 ? md_data : 0);
         acc_cyc.push_back(cyc);
      end
      ctrl_wr = wr && wa == 0;
      abort = !md_en || (ctrl_wr && !wd[0]);
      ph = md_phase;
      case (ph)
         0: if (ctrl_wr && wd[0]) begin md_phase = 1; md_step = 0; md_data = pat(md_pattern, 0); end
         1: if (!wreq) begin
               if (abort) md_phase = 3;
               else begin md_phase = 2; md_wait_end = cyc + pmax(md_period); end
            end
         2: if (abort) md_phase = 3;
            else if (cyc == md_wait_end) begin
               if (md_step < 3 || md_loop) begin
                  md_step = (md_step + 1) % 4; md_phase = 1; md_data = pat(md_pattern, md_step);
               end else md_phase = 3;
            end
         default: if (!wreq) md_phase = 0;
      endcase
      if (ctrl_wr) begin
         md_loop = wd[1];
         if (ph == 0 || !wd[0]) md_en = wd[0];
      end
      if (wr && wa == 1) md_period = wd & 'hFFFFFF;
      if (wr && wa == 2) md_pattern = wd & 'hFFF;
      if (ph == 3 && !wreq) md_en = 0;
      cyc++;
   endtask

   task automatic idle(input int n);
      repeat (n) cyc_step(0, 0, 0, 0, 0, 0);
   endtask

   task automatic wreg(input int a, input int d);
      cyc_step(1, a, d, 0, 0, 0);
   endtask

   task automatic clear_log();
      acc_data.delete();
      acc_cyc.delete();
   endtask

   task automatic wait_phase(input int p, input int lim);
      int k = 0;
      while (md_phase != p && k < lim) begin idle(1); k++; end
      chk("wait_phase_timeout", md_phase, p);
   endtask

   task automatic do_reset();
      @(negedge clk);
      chipselect = 0; write_n = 1; m_waitrequest = 0;
      reset_n = 0;
      #1;
      model_reset();
      chk("rst_m_write", {31'b0, m_write}, 0);
      chk("rst_busy", {31'b0, busy}, 0);
      chk("rst_m_writedata", m_writedata, 0);
      repeat (2) @(negedge clk);
      reset_n = 1;
   endtask

   task automatic chk_seq(input string name, input int exp[], input int gap);
      chk({name, "_count"}, acc_data.size() >= exp.size() ? 1 : 0, 1);
      for (int i = 0; i < exp.size(); i++)
         chk({name, "_data"}, (i < acc_data.size()) ? acc_data[i] : 32'hFFFF_FFFF, exp[i]);
      for (int i = 0; i + 1 < exp.size(); i++)
         chk({name, "_gap"}, (i + 1 < acc_cyc.size()) ? 32'(acc_cyc[i+1] - acc_cyc[i]) : 32'hFFFF_FFFF, gap);
   endtask

   initial begin
      int r;
      model_reset();
      do_reset();
      for (int a = 0; a < 4; a++) begin
         cyc_step(0, 0, 0, 1, a, 0);
         chk("reset_readdata", readdata, 0);
      end
      // one-shot run: patterns 1,4,7,3 then a clear write, 6 cycles apart
      wreg(2, 'h7E1);
      wreg(1, 5);
      clear_log();
      wreg(0, 1);
      idle(40);
      chk_seq("oneshot", '{1, 4, 7, 3, 0}, 6);
      chk("oneshot_len", acc_data.size(), 5);
      chk("oneshot_busy", {31'b0, busy}, 0);
      // looping run, then abort from WAIT
      clear_log();
      wreg(0, 3);
      idle(40);
      chk_seq("loop", '{1, 4, 7, 3, 1, 4}, 6);
      foreach (acc_data[i]) chk("loop_no_clear", acc_data[i] != 0 ? 1 : 0, 1);
      wait_phase(2, 20);
      clear_log();
      wreg(0, 0);
      idle(4);
      chk("abort_len", acc_data.size(), 1);
      chk("abort_clear", acc_data.size() > 0 ? acc_data[0] : 32'hFFFF_FFFF, 0);
      chk("abort_busy", {31'b0, busy}, 0);
      // PERIOD 0 and PERIOD 1 both give 2-cycle spacing
      for (int p = 0; p < 2; p++) begin
         wreg(1, p);
         clear_log();
         wreg(0, 1);
         idle(15);
         chk_seq("short_period", '{1, 4, 7, 3, 0}, 2);
      end
      // stalled step write is held and the step timer waits for acceptance
      wreg(1, 3);
      clear_log();
      wreg(0, 1);
      repeat (4) begin
         cyc_step(0, 0, 0, 0, 0, 1);
         chk("stall_m_write", {31'b0, m_write}, 1);
         chk("stall_data", m_writedata, 1);
      end
      idle(20);
      chk_seq("stall", '{1, 4, 7, 3, 0}, 4);
      // abort while the step write is stalled: that write completes, then the clear
      clear_log();
      wreg(0, 1);
      cyc_step(0, 0, 0, 0, 0, 1);
      cyc_step(1, 0, 0, 0, 0, 1);
      cyc_step(0, 0, 0, 0, 0, 1);
      chk("abort_stall_data", m_writedata, 1);
      idle(4);
      chk("abort_stall_len", acc_data.size(), 2);
      chk_seq("abort_stall", '{1, 0}, 1);
      // reset in the middle of WAIT
      wreg(0, 1);
      wait_phase(2, 10);
      do_reset();
      cyc_step(0, 0, 0, 1, 0, 0);
      chk("post_reset_ctrl", readdata, 0);
      // random traffic
      for (int i = 0; i < 4000; i++) begin
         bit wq;
         r = $urandom_range(0, 99);
         wq = ($urandom_range(0, 99) < 30);
         if (i % 1000 == 999) do_reset();
         else if (r < 4) cyc_step(1, 0, $urandom_range(0, 3), 0, 0, wq);
         else if (r < 6) cyc_step(1, 1, $urandom_range(0, 6), 0, 0, wq);
         else if (r < 8) cyc_step(1, 2, $urandom, 0, 0, wq);
         else if (r < 9) cyc_step(1, 3, $urandom, 0, 0, wq);
         else if (r < 30) cyc_step(0, 0, 0, 1, $urandom_range(0, 3), wq);
         else cyc_step(0, 0, 0, 0, 0, wq);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
